// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell reused by the serial adder controller.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder reused LSB-first across WIDTH clocks.
// Optional signed-overflow output enabled by `define SERIAL_ADD_OVF_EN.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fa_s, fa_c;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   full_adder u_fa (
      .x (a_sr_q[0]),
      .y (b_sr_q[0]),
      .z (carry_q),
      .s (fa_s),
      .c (fa_c)
   );

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            // shift-then-insert keeps WIDTH=1 legal (no [0:1] slice)
            sum_sr_d = sum_sr_q >> 1;
            sum_sr_d[WIDTH-1] = fa_s;
            carry_d  = fa_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               sum_d   = sum_sr_d;
               cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d   = carry_q ^ fa_c;
`endif
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == ST_SHIFT);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed vectors, results checked on done.
module tb_serial_add_ctrl;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned done_seen = 0;
   int unsigned done_expected = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected result per done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("sum", 32'(sum), 32'(e.sum));
               chk("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
               chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.sum = s;
      e.cout = c;
      e.ovf = o;
      exp_q.push_back(e);
      done_expected++;
   endtask

   // Issue one addition and check busy/done timing relative to accept edge E.
   task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic [W-1:0] es, input logic ec, input logic eo);
      @(negedge clk);
      a = av;
      b = bv;
      cin = cv;
      start = 1'b1;
      push_exp(es, ec, eo);
      @(posedge clk); #1;
      start = 1'b0;
      a = ~av;
      b = ~bv;
      cin = ~cv;
      chk("busy_after_accept", 32'(busy), 32'd1);
      for (int k = 1; k < int'(W); k++) begin
         @(posedge clk); #1;
      end
      chk("busy_last_shift", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("busy_in_done", 32'(busy), 32'd0);
      chk("done_pulse", 32'(done), 32'd1);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_sum", 32'(sum), 32'd0);
      chk("reset_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("reset_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      do_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
      do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

      // start held through the whole operation with changing operands
      @(negedge clk);
      a = 8'h12;
      b = 8'h34;
      cin = 1'b0;
      start = 1'b1;
      push_exp(8'h46, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("hold_busy_accept", 32'(busy), 32'd1);
      for (int k = 1; k <= int'(W); k++) begin
         a = 8'(k * 37);
         b = 8'(k * 11);
         @(posedge clk); #1;
      end
      chk("hold_done_pulse", 32'(done), 32'd1);
      chk("hold_sum_first", 32'(sum), 32'h46);
      start = 1'b0;
      @(posedge clk); #1;
      chk("hold_no_restart", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("hold_idle", 32'(busy), 32'd0);

      // reset after 4 SHIFT edges discards the partial result
      @(negedge clk);
      a = 8'h33;
      b = 8'h44;
      cin = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_reset_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(busy), 32'd0);

      do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("done_count", 32'(done_seen), 32'(done_expected));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
